// File: rtl/pixel_arb_pkg.sv
// Shared defaults and encodings for the pixel RAM arbiter.
package pixel_arb_pkg;

  localparam int ADDR_W_DEFAULT = 17;
  localparam int DATA_W_DEFAULT = 8;

  // Which requester owns the read data returning from the RAM next cycle
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_CONV = 2'd2
  } tag_e;

  // Which conv requester wins a tie between read and write
  typedef enum logic {
    RD_NEXT = 1'b0,
    WR_NEXT = 1'b1
  } ptr_e;

endpackage

// File: rtl/pixel_arb_rr.sv
// Two-way round-robin pick between conv read and conv write, with its pointer.
module pixel_arb_rr
  import pixel_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic rd_req,
  input  logic wr_req,
  output logic rd_gnt,
  output logic wr_gnt
);

  ptr_e ptr_q;
  ptr_e ptr_d;

  // Pick a winner; a lone requester wins regardless of the pointer
  always_comb begin
    rd_gnt = en && rd_req && (!wr_req || (ptr_q == RD_NEXT));
    wr_gnt = en && wr_req && (!rd_req || (ptr_q == WR_NEXT));
    ptr_d  = ptr_q;
    if (rd_gnt) begin
      ptr_d = WR_NEXT;
    end else if (wr_gnt) begin
      ptr_d = RD_NEXT;
    end
  end

  // Pointer moves only on a conv grant, toward the other requester
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= RD_NEXT;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/pixel_ram_arbiter.sv
// Single-port pixel RAM arbiter: display scanout first, then conv read/write
// round-robin. One access per cycle, reads return one cycle after grant.
module pixel_ram_arbiter
  import pixel_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              conv_rd_req,
  input  logic [ADDR_W-1:0] conv_rd_addr,
  output logic              conv_rd_gnt,
  output logic              conv_rvalid,
  output logic [DATA_W-1:0] conv_rdata,
  input  logic              conv_wr_req,
  input  logic [ADDR_W-1:0] conv_wr_addr,
  input  logic [DATA_W-1:0] conv_wr_data,
  output logic              conv_wr_gnt,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  tag_e              tag_q;
  tag_e              tag_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              conv_en;

  assign conv_en = rst_n && !disp_req;

  pixel_arb_rr u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (conv_en),
    .rd_req (conv_rd_req),
    .wr_req (conv_wr_req),
    .rd_gnt (conv_rd_gnt),
    .wr_gnt (conv_wr_gnt)
  );

  // Display always wins; drive the RAM from whoever was granted, else hold address
  always_comb begin
    disp_gnt  = rst_n && disp_req;
    ram_we    = conv_wr_gnt;
    ram_wdata = conv_wr_gnt ? conv_wr_data : '0;
    if (disp_gnt) begin
      ram_addr = disp_addr;
    end else if (conv_rd_gnt) begin
      ram_addr = conv_rd_addr;
    end else if (conv_wr_gnt) begin
      ram_addr = conv_wr_addr;
    end else begin
      ram_addr = addr_q;
    end
    addr_d = ram_addr;
  end

  // Next read tag and saturating count of denied conv cycles
  always_comb begin
    tag_d = TAG_NONE;
    if (disp_gnt) begin
      tag_d = TAG_DISP;
    end else if (conv_rd_gnt) begin
      tag_d = TAG_CONV;
    end
    cnt_d = cnt_q;
    if ((conv_rd_req || conv_wr_req) && !conv_rd_gnt && !conv_wr_gnt && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset clears tag, held address and counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_q  <= TAG_NONE;
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      tag_q  <= tag_d;
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Read data returns to the tagged requester; nothing is reported during reset
  always_comb begin
    disp_rvalid  = rst_n && (tag_q == TAG_DISP);
    conv_rvalid  = rst_n && (tag_q == TAG_CONV);
    disp_rdata   = ram_rdata;
    conv_rdata   = ram_rdata;
    conflict_cnt = cnt_q;
  end

endmodule

// File: tb/tb_pixel_ram_arbiter.sv
// Directed bench for pixel_ram_arbiter with a behavioural single-port RAM.
module tb_pixel_ram_arbiter;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;
  logic              conv_rd_req;
  logic [ADDR_W-1:0] conv_rd_addr;
  logic              conv_rd_gnt;
  logic              conv_rvalid;
  logic [DATA_W-1:0] conv_rdata;
  logic              conv_wr_req;
  logic [ADDR_W-1:0] conv_wr_addr;
  logic [DATA_W-1:0] conv_wr_data;
  logic              conv_wr_gnt;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [CNT_W-1:0]  conflict_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always #5 clk = ~clk;

  // Registered-read RAM; a write lands at the edge so the next read sees it
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  pixel_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .conv_rd_req(conv_rd_req), .conv_rd_addr(conv_rd_addr), .conv_rd_gnt(conv_rd_gnt),
    .conv_rvalid(conv_rvalid), .conv_rdata(conv_rdata),
    .conv_wr_req(conv_wr_req), .conv_wr_addr(conv_wr_addr), .conv_wr_data(conv_wr_data),
    .conv_wr_gnt(conv_wr_gnt),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .conflict_cnt(conflict_cnt)
  );

  task automatic applyStimulus(input logic dr, input logic [ADDR_W-1:0] da,
                               input logic rr, input logic [ADDR_W-1:0] ra,
                               input logic wr, input logic [ADDR_W-1:0] wa,
                               input logic [DATA_W-1:0] wd);
    disp_req = dr; disp_addr = da;
    conv_rd_req = rr; conv_rd_addr = ra;
    conv_wr_req = wr; conv_wr_addr = wa; conv_wr_data = wd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkGrants(input string tag, input logic d, input logic r, input logic w);
    checkOutput({tag, " disp_gnt"}, 32'(disp_gnt), 32'(d));
    checkOutput({tag, " rd_gnt"}, 32'(conv_rd_gnt), 32'(r));
    checkOutput({tag, " wr_gnt"}, 32'(conv_wr_gnt), 32'(w));
    checkOutput({tag, " ram_we"}, 32'(ram_we), 32'(w));
  endtask

  initial begin
    // Reset with every request raised: grants must stay low
    rst_n = 1'b0;
    applyStimulus(1'b1, 17'h10, 1'b1, 17'h20, 1'b1, 17'h30, 8'h55);
    checkGrants("rst comb", 1'b0, 1'b0, 1'b0);
    tick; tick;
    checkOutput("rst disp_rvalid", 32'(disp_rvalid), 0);
    checkOutput("rst conv_rvalid", 32'(conv_rvalid), 0);
    checkOutput("rst cnt", 32'(conflict_cnt), 0);
    checkOutput("rst ram_addr", 32'(ram_addr), 0);

    // Display beats both conv requests for 4 cycles
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 17'h10 + 17'(i), 1'b1, 17'h20, 1'b1, 17'h30, 8'h55);
      checkGrants("disp prio", 1'b1, 1'b0, 1'b0);
      checkOutput("disp prio addr", 32'(ram_addr), 32'h10 + i);
      tick;
      checkOutput("disp prio rvalid", 32'(disp_rvalid), 1);
      checkOutput("disp prio cnt", 32'(conflict_cnt), 32'(i + 1));
    end

    // Both conv requests, display idle: RD,WR,RD,WR,RD,WR
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 17'h0, 1'b1, 17'h00200, 1'b1, 17'h00300, 8'h3C);
      checkGrants("rr", 1'b0, (i % 2) == 0, (i % 2) == 1);
      checkOutput("rr addr", 32'(ram_addr), (i % 2) == 0 ? 32'h200 : 32'h300);
      tick;
      checkOutput("rr conv_rvalid", 32'(conv_rvalid), 32'((i % 2) == 0));
      checkOutput("rr cnt", 32'(conflict_cnt), 4);
    end

    // Write A5 to 0x100, then read it back the very next cycle
    applyStimulus(1'b0, 17'h0, 1'b0, 17'h0, 1'b1, 17'h00100, 8'hA5);
    checkGrants("raw wr", 1'b0, 1'b0, 1'b1);
    checkOutput("raw wr addr", 32'(ram_addr), 32'h100);
    checkOutput("raw wr data", 32'(ram_wdata), 32'hA5);
    tick;
    applyStimulus(1'b0, 17'h0, 1'b1, 17'h00100, 1'b0, 17'h0, 8'h00);
    checkGrants("raw rd", 1'b0, 1'b1, 1'b0);
    tick;
    checkOutput("raw conv_rvalid", 32'(conv_rvalid), 1);
    checkOutput("raw conv_rdata", 32'(conv_rdata), 32'hA5);
    checkOutput("raw disp_rvalid", 32'(disp_rvalid), 0);

    // Idle: address held, no write, no rvalid
    applyStimulus(1'b0, 17'h0, 1'b0, 17'h0, 1'b0, 17'h0, 8'h00);
    checkGrants("idle", 1'b0, 1'b0, 1'b0);
    checkOutput("idle addr hold", 32'(ram_addr), 32'h100);
    tick;
    checkOutput("idle conv_rvalid", 32'(conv_rvalid), 0);

    // Load 0..2, then display reads them back-to-back
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 17'h0, 1'b0, 17'h0, 1'b1, 17'(i), 8'(8'h11 * (i + 1)));
      tick;
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 17'(i), 1'b0, 17'h0, 1'b0, 17'h0, 8'h00);
      checkGrants("b2b", 1'b1, 1'b0, 1'b0);
      tick;
      checkOutput("b2b disp_rvalid", 32'(disp_rvalid), 1);
      checkOutput("b2b disp_rdata", 32'(disp_rdata), 32'h11 * (i + 1));
      checkOutput("b2b conv_rvalid", 32'(conv_rvalid), 0);
    end
    applyStimulus(1'b0, 17'h0, 1'b0, 17'h0, 1'b0, 17'h0, 8'h00);
    tick;
    checkOutput("b2b end rvalid", 32'(disp_rvalid), 0);

    // Conv read granted, then reset before the next edge: no rvalid survives
    applyStimulus(1'b0, 17'h0, 1'b1, 17'h00100, 1'b0, 17'h0, 8'h00);
    checkGrants("rstrd", 1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkGrants("rstrd comb", 1'b0, 1'b0, 1'b0);
    tick;
    checkOutput("rstrd conv_rvalid", 32'(conv_rvalid), 0);
    checkOutput("rstrd disp_rvalid", 32'(disp_rvalid), 0);
    checkOutput("rstrd cnt", 32'(conflict_cnt), 0);
    checkOutput("rstrd ram_addr", 32'(ram_addr), 0);
    checkOutput("rstrd ram_wdata", 32'(ram_wdata), 0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 17'h0, 1'b1, 17'h00200, 1'b1, 17'h00300, 8'h3C);
    checkGrants("rstrd ptr", 1'b0, 1'b1, 1'b0);
    tick;

    // Saturation: climb to all-ones minus 1, then deny 3 more
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 17'h5, 1'b1, 17'h00200, 1'b0, 17'h0, 8'h00);
      tick;
    end
    checkOutput("sat pre", 32'(conflict_cnt), 6);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 17'h5, 1'b1, 17'h00200, 1'b0, 17'h0, 8'h00);
      tick;
      checkOutput("sat", 32'(conflict_cnt), 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
